// File: rtl/ddr_read_burst_gen_pkg.sv
// -----------------------------------------------------------------------------
// ddr_read_burst_gen_pkg
// Shared widths and limits for the DDR read burst generator (GLOBAL_PARAM role).
// Imported by ddr_rd_chunk_calc and ddr_read_burst_gen.
// -----------------------------------------------------------------------------
package ddr_read_burst_gen_pkg;

    localparam int DDR_ADDR_W         = 32;
    localparam int BURST_W            = 16;
    localparam int DDR_DATA_W         = 512;
    localparam int AXI_MAX_LEN        = 16;
    localparam int AXI_MAX_OUTS       = 8;
    localparam int DDR_BYTES_PER_BEAT = DDR_DATA_W / 8;

    // Width of a beat count for one AXI burst (1..256).
    localparam int AR_LEN_W   = 9;
    localparam int PAGE_BYTES = 4096;

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_rd_chunk_calc.sv
// -----------------------------------------------------------------------------
// ddr_rd_chunk_calc
// Combinational: length in beats of the next AXI read burst.
//   len = min(MAX_LEN, remaining)                      (default build)
//   len = min(MAX_LEN, remaining, beats left in 4 KB)   (DDR_RD_4K_SPLIT_EN)
// Ports:
//   remaining  in   beats still to request in the current row
//   addr       in   byte address of the next burst
//   len        out  burst length in beats (1..256)
// -----------------------------------------------------------------------------
module ddr_rd_chunk_calc #(
    parameter int ADDR_W         = ddr_read_burst_gen_pkg::DDR_ADDR_W,
    parameter int BURST_W        = ddr_read_burst_gen_pkg::BURST_W,
    parameter int MAX_LEN        = ddr_read_burst_gen_pkg::AXI_MAX_LEN,
    parameter int BYTES_PER_BEAT = ddr_read_burst_gen_pkg::DDR_BYTES_PER_BEAT
) (
    input  logic [BURST_W-1:0]                           remaining,
    input  logic [ADDR_W-1:0]                            addr,
    output logic [ddr_read_burst_gen_pkg::AR_LEN_W-1:0]  len
);
    import ddr_read_burst_gen_pkg::*;

    int unsigned cap;
`ifdef DDR_RD_4K_SPLIT_EN
    int unsigned page_room;
`endif

    // Only the low 12 bits matter, and only in the page-split build.
    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        cap = umin(int'(MAX_LEN), 32'(remaining));
`ifdef DDR_RD_4K_SPLIT_EN
        page_room = (PAGE_BYTES - 32'(addr[11:0])) / BYTES_PER_BEAT;
        // A start inside the last beat of a page gives 0; issue one beat so
        // the generator still makes progress.
        if (page_room == 0) page_room = 1;
        cap = umin(cap, page_room);
`endif
        len = AR_LEN_W'(cap);
    end

endmodule

// File: rtl/ddr_read_burst_gen.sv
// -----------------------------------------------------------------------------
// ddr_read_burst_gen
// Expands one read descriptor (start, beats/row, row stride, rows-1) into AXI4
// AR bursts and passes R data through to the buffer-fill logic, flagging the
// final beat of the descriptor. conf_ready = idle and all data delivered.
// Optional: define DDR_RD_4K_SPLIT_EN to keep bursts inside 4 KB pages.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   conf_valid/conf_ready            descriptor handshake
//   conf_st_addr, conf_burst,
//   conf_step, conf_burst_num        descriptor fields
//   m_ar*                            AXI read address channel
//   m_r*                             AXI read data channel
//   dout_data/valid/ready/last       data stream to buffer logic
// -----------------------------------------------------------------------------
module ddr_read_burst_gen #(
    parameter int ADDR_W     = ddr_read_burst_gen_pkg::DDR_ADDR_W,
    parameter int BURST_W    = ddr_read_burst_gen_pkg::BURST_W,
    parameter int DDR_DATA_W = ddr_read_burst_gen_pkg::DDR_DATA_W,
    parameter int MAX_LEN    = ddr_read_burst_gen_pkg::AXI_MAX_LEN,
    parameter int MAX_OUTS   = ddr_read_burst_gen_pkg::AXI_MAX_OUTS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  conf_valid,
    output logic                  conf_ready,
    input  logic [ADDR_W-1:0]     conf_st_addr,
    input  logic [BURST_W-1:0]    conf_burst,
    input  logic [ADDR_W-1:0]     conf_step,
    input  logic [BURST_W-1:0]    conf_burst_num,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [7:0]            m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DDR_DATA_W-1:0] m_rdata,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [DDR_DATA_W-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);
    import ddr_read_burst_gen_pkg::*;

    localparam int BYTES_PER_BEAT = DDR_DATA_W / 8;
    localparam int CNT_W          = 2 * BURST_W;
    localparam int OUT_W          = $clog2(MAX_OUTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]   row_addr, row_step, cur_addr;
    logic [BURST_W-1:0]  row_beats, last_row, row_idx, beat_off, remaining;
    logic [CNT_W-1:0]    total, rx_cnt;
    logic [OUT_W-1:0]    outstanding;
    logic [AR_LEN_W-1:0] chunk_len;
    logic [BURST_W:0]    next_off;
    logic                accept, ar_fire, r_fire, rlast_fire;
    logic                busy, at_limit, row_end;

    // ---------------- handshakes / data pass-through ----------------
    assign accept     = conf_valid && conf_ready;
    assign ar_fire    = m_arvalid && m_arready;
    assign m_rready   = dout_ready;
    assign dout_data  = m_rdata;
    assign dout_valid = m_rvalid;
    assign r_fire     = m_rvalid && dout_ready;
    // Guard against a stray rlast driving the counter below zero.
    assign rlast_fire = r_fire && m_rlast && (outstanding != '0);
    assign busy       = (state != ST_IDLE);
    assign at_limit   = (outstanding == OUT_W'(MAX_OUTS));
    assign dout_last  = busy && m_rvalid && (rx_cnt == total - CNT_W'(1));

    // ---------------- burst address / length ----------------
    assign remaining = row_beats - beat_off;
    assign cur_addr  = row_addr + ADDR_W'(beat_off) * ADDR_W'(BYTES_PER_BEAT);
    assign next_off  = {1'b0, beat_off} + (BURST_W+1)'(chunk_len);
    assign row_end   = (next_off == {1'b0, row_beats});

    ddr_rd_chunk_calc #(
        .ADDR_W         (ADDR_W),
        .BURST_W        (BURST_W),
        .MAX_LEN        (MAX_LEN),
        .BYTES_PER_BEAT (BYTES_PER_BEAT)
    ) u_chunk (
        .remaining (remaining),
        .addr      (cur_addr),
        .len       (chunk_len)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            conf_ready <= 1'b1;
        end else begin
            state      <= state_next;
            conf_ready <= (state_next == ST_IDLE);
        end
    end

    always_comb begin
        state_next = state;
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arlen    = '0;
        case (state)
            ST_IDLE: begin
                // A zero-beat descriptor is consumed without leaving IDLE.
                if (accept && (conf_burst != '0)) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Address/length only move on a handshake and outstanding can
                // only grow on a handshake, so a raised AR stays stable.
                m_arvalid = !at_limit;
                m_araddr  = cur_addr;
                m_arlen   = 8'(chunk_len - AR_LEN_W'(1));
                if (!at_limit && m_arready && row_end && (row_idx == last_row))
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (rx_cnt == total) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- descriptor walk and beat counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_addr  <= '0;
            row_step  <= '0;
            row_beats <= '0;
            last_row  <= '0;
            total     <= '0;
            row_idx   <= '0;
            beat_off  <= '0;
            rx_cnt    <= '0;
        end else if (accept) begin
            row_addr  <= conf_st_addr;
            row_step  <= conf_step;
            row_beats <= conf_burst;
            last_row  <= conf_burst_num;
            total     <= CNT_W'(conf_burst) * (CNT_W'(conf_burst_num) + CNT_W'(1));
            row_idx   <= '0;
            beat_off  <= '0;
            rx_cnt    <= '0;
        end else begin
            if (ar_fire) begin
                if (row_end) begin
                    beat_off <= '0;
                    row_idx  <= row_idx + BURST_W'(1);
                    row_addr <= row_addr + row_step;
                end else begin
                    beat_off <= next_off[BURST_W-1:0];
                end
            end
            if (r_fire && busy) rx_cnt <= rx_cnt + CNT_W'(1);
        end
    end

    // ---------------- outstanding AR transactions ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (ar_fire && !rlast_fire) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!ar_fire && rlast_fire) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

endmodule

// File: tb/tb_ddr_read_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_ddr_read_burst_gen
// Directed + randomized bench for ddr_read_burst_gen. A reference model turns
// each descriptor into the expected AR list and beat count; a small AXI slave
// answers ARs with random data which must appear unchanged on dout.
// -----------------------------------------------------------------------------
module tb_ddr_read_burst_gen;

    localparam int DW       = 512;
    localparam int BPB      = DW / 8;
    localparam int MAX_LEN  = 16;
    localparam int MAX_OUTS = 8;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          conf_valid = 1'b0;
    logic          conf_ready;
    logic [31:0]   conf_st_addr = '0;
    logic [15:0]   conf_burst = '0;
    logic [31:0]   conf_step = '0;
    logic [15:0]   conf_burst_num = '0;
    logic [31:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic          m_arvalid;
    logic          m_arready = 1'b1;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rlast = 1'b0;
    logic          m_rvalid = 1'b0;
    logic          m_rready;
    logic [DW-1:0] dout_data;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          dout_last;

    int checks = 0;
    int errors = 0;

    // reference model / slave state
    ar_t           exp_ar[$];
    int            pending[$];
    int            exp_total = 0;
    int            beat_idx = 0;
    int            desc_ars = 0;
    int            outs = 0;
    int            cur_rem = 0;
    bit            consumed = 0;
    bit            ar_wait = 0;
    logic [31:0]   held_addr;
    logic [7:0]    held_len;
    logic [DW-1:0] cur_data = '0;
    bit            r_hold = 0;
    bit            rnd_mode = 0;

    ddr_read_burst_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .conf_valid     (conf_valid),
        .conf_ready     (conf_ready),
        .conf_st_addr   (conf_st_addr),
        .conf_burst     (conf_burst),
        .conf_step      (conf_step),
        .conf_burst_num (conf_burst_num),
        .m_araddr       (m_araddr),
        .m_arlen        (m_arlen),
        .m_arvalid      (m_arvalid),
        .m_arready      (m_arready),
        .m_rdata        (m_rdata),
        .m_rlast        (m_rlast),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .dout_data      (dout_data),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_last      (dout_last)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input logic [DW-1:0] got, input logic [DW-1:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beats allowed in one burst starting at addr with rem beats left in the row.
    function automatic int model_chunk(input logic [31:0] addr, input int rem);
        int l;
        l = (rem < MAX_LEN) ? rem : MAX_LEN;
`ifdef DDR_RD_4K_SPLIT_EN
        begin
            int room;
            room = (4096 - int'(addr[11:0])) / BPB;
            if (room < 1) room = 1;
            if (room < l) l = room;
        end
`endif
        return l;
    endfunction

    // Called at posedge+1; pulses conf_valid for one cycle.
    task automatic send_desc(input logic [31:0] st, input int burst, input logic [31:0] step,
                             input int num);
        exp_total = burst * (num + 1);
        beat_idx  = 0;
        desc_ars  = 0;
        for (int r = 0; r <= num; r++) begin
            int off;
            off = 0;
            while (off < burst) begin
                ar_t e;
                int  l;
                e.addr = st + 32'(r) * step + 32'(off * BPB);
                l      = model_chunk(e.addr, burst - off);
                e.len  = 8'(l - 1);
                exp_ar.push_back(e);
                off += l;
            end
        end
        chk(conf_ready, 1, "conf_ready_before_accept");
        conf_valid     = 1'b1;
        conf_st_addr   = st;
        conf_burst     = 16'(burst);
        conf_step      = step;
        conf_burst_num = 16'(num);
        @(posedge clk); #1;
        conf_valid = 1'b0;
        if (burst > 0) chk(conf_ready, 0, "conf_ready_busy");
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!conf_ready && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(conf_ready, 1, {tag, "_idle_timeout"});
        chk(exp_ar.size(), 0, {tag, "_ars_left"});
        chk(beat_idx, exp_total, {tag, "_beats"});
    endtask

    // AXI slave + monitor: sample at negedge, drive at posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ar_wait) begin
                chk(m_arvalid, 1, "ar_valid_held");
                chk(m_araddr, held_addr, "ar_addr_held");
                chk(m_arlen, held_len, "ar_len_held");
            end
            ar_wait   = m_arvalid && !m_arready;
            held_addr = m_araddr;
            held_len  = m_arlen;
            if (outs == MAX_OUTS) chk(m_arvalid, 0, "arvalid_at_limit");
            if (m_arvalid && m_arready) begin
                chk(outs < MAX_OUTS, 1, "outs_below_limit");
                chk(exp_ar.size() > 0, 1, "ar_expected");
                if (exp_ar.size() > 0) begin
                    ar_t e;
                    e = exp_ar.pop_front();
                    chk(m_araddr, e.addr, "ar_addr");
                    chk(m_arlen, e.len, "ar_len");
                end
                pending.push_back(int'(m_arlen) + 1);
                desc_ars++;
            end
            if (m_rvalid && m_rready) begin
                chk(dout_valid, 1, "dout_valid");
                chk(dout_data, cur_data, "dout_data");
                chk(dout_last, (beat_idx == exp_total - 1), "dout_last");
                beat_idx++;
                cur_rem--;
                consumed = 1;
                if (m_rlast) begin
                    chk(outs > 0, 1, "outs_nonneg");
                    if (outs > 0) outs--;
                end
            end
            if (m_arvalid && m_arready) outs++;
        end
        @(posedge clk); #1;
        if (!rst_n) begin
            pending.delete();
            cur_rem  = 0;
            consumed = 0;
            outs     = 0;
            ar_wait  = 0;
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
        end else begin
            if (!(m_rvalid && !consumed)) begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                if (cur_rem == 0 && pending.size() > 0) cur_rem = pending.pop_front();
                if (cur_rem > 0 && !r_hold && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                    for (int k = 0; k < DW / 32; k++) cur_data[k*32 +: 32] = $urandom();
                    m_rdata  = cur_data;
                    m_rvalid = 1'b1;
                    m_rlast  = (cur_rem == 1);
                end
            end
            consumed = 0;
        end
        m_arready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        // ---- reset values ----
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk(conf_ready, 1, "rst_conf_ready");
        chk(m_arvalid, 0, "rst_arvalid");
        chk(m_araddr, 0, "rst_araddr");
        chk(m_arlen, 0, "rst_arlen");
        chk(dout_last, 0, "rst_dout_last");
        @(posedge clk); #1;

        // ---- single burst ----
        send_desc(32'h1000, 8, 32'h0, 0);
        wait_idle(500, "single");

        // ---- row split by MAX_LEN ----
        send_desc(32'h0, 40, 32'h0, 0);
        wait_idle(500, "split");

        // ---- strided rows, back-to-back accept ----
        send_desc(32'h2000, 4, 32'h3000, 2);
        wait_idle(500, "stride");

        // ---- zero-beat descriptor ----
        send_desc(32'h4000, 0, 32'h0, 3);
        @(posedge clk); #1;
        chk(conf_ready, 1, "zero_conf_ready");
        repeat (5) @(posedge clk);
        #1;
        chk(desc_ars, 0, "zero_no_ar");

        // ---- outstanding limit ----
        r_hold = 1;
        send_desc(32'h10000, 16, 32'h400, 9);
        repeat (30) @(negedge clk);
        chk(desc_ars, 8, "outs_ars_while_held");
        chk(m_arvalid, 0, "outs_arvalid_low");
        r_hold = 0;
        begin
            int n;
            n = 0;
            while (desc_ars < 9 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk(desc_ars >= 9, 1, "outs_ninth_ar");
        end
        wait_idle(2000, "outs");

        // ---- randomized handshakes and descriptors ----
        rnd_mode = 1;
        for (int d = 0; d < 8; d++) begin
            logic [31:0] st, step;
            int          b, nr;
            st   = {10'($urandom_range(0, 1023)), 16'($urandom_range(0, 65535)), 6'b0};
            step = {20'($urandom_range(0, 1023)), 6'b0};
            b    = $urandom_range(1, 40);
            nr   = $urandom_range(0, 3);
            send_desc(st, b, step, nr);
            wait_idle(4000, "rand");
        end
        rnd_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // ---- burst near a 4 KB page boundary ----
        send_desc(32'h0FC0, 8, 32'h0, 0);
        wait_idle(500, "page");

        // ---- reset while issuing ----
        r_hold = 1;
        send_desc(32'h20000, 16, 32'h1000, 20);
        repeat (3) @(posedge clk);
        #1;
        chk(m_arvalid, 1, "pre_rst_arvalid");
        #2 rst_n = 1'b0;
        #1;
        chk(conf_ready, 1, "midrst_conf_ready");
        chk(m_arvalid, 0, "midrst_arvalid");
        exp_ar.delete();
        exp_total = 0;
        beat_idx  = 0;
        r_hold    = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send_desc(32'h3000, 20, 32'h800, 1);
        wait_idle(1000, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
